// File: rtl/td4_pkg.sv
// td4_pkg: shared definitions for the TD4 4-bit CPU sequencer.
//   - opcode constants of the TD4 instruction set
//   - adder source select, load destination and FSM state encodings
package td4_pkg;

    localparam logic [3:0] OP_ADD_A  = 4'b0000;  // ADD A,Im
    localparam logic [3:0] OP_MOV_AB = 4'b0001;  // MOV A,B
    localparam logic [3:0] OP_IN_A   = 4'b0010;  // IN  A
    localparam logic [3:0] OP_MOV_AI = 4'b0011;  // MOV A,Im
    localparam logic [3:0] OP_MOV_BA = 4'b0100;  // MOV B,A
    localparam logic [3:0] OP_ADD_B  = 4'b0101;  // ADD B,Im
    localparam logic [3:0] OP_IN_B   = 4'b0110;  // IN  B
    localparam logic [3:0] OP_MOV_BI = 4'b0111;  // MOV B,Im
    localparam logic [3:0] OP_OUT_B  = 4'b1001;  // OUT B
    localparam logic [3:0] OP_OUT_I  = 4'b1011;  // OUT Im
    localparam logic [3:0] OP_JNC    = 4'b1110;  // JNC Im
    localparam logic [3:0] OP_JMP    = 4'b1111;  // JMP Im

    typedef enum logic [1:0] {
        SRC_A    = 2'd0,
        SRC_B    = 2'd1,
        SRC_IN   = 2'd2,
        SRC_ZERO = 2'd3
    } src_t;

    typedef enum logic [1:0] {
        DST_NONE = 2'd0,
        DST_A    = 2'd1,
        DST_B    = 2'd2,
        DST_OUT  = 2'd3
    } dst_t;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_EXEC  = 1'b1
    } state_t;

endpackage

// File: rtl/td4_sequencer_if.sv
// td4_sequencer_if: register load bus between the sequencer and the
// A, B and output-port registers.
//   Im       : adder result, D input of every register
//   LOAD_A/B : load strobes for the A and B registers
//   LOAD_OUT : load strobe for the output-port register
//   A, B     : current register contents fed back to the adder
// master = sequencer side, slave = register side.
interface td4_sequencer_if #(
    parameter int DW = 4
);
    logic [DW-1:0] Im;
    logic          LOAD_A;
    logic          LOAD_B;
    logic          LOAD_OUT;
    logic [DW-1:0] A;
    logic [DW-1:0] B;

    modport master (
        output Im, LOAD_A, LOAD_B, LOAD_OUT,
        input  A, B
    );

    modport slave (
        input  Im, LOAD_A, LOAD_B, LOAD_OUT,
        output A, B
    );
endinterface

// File: rtl/td4_decode.sv
// td4_decode: combinational TD4 opcode decoder.
//   opcode : instruction bits [7:4]
//   src    : adder source select
//   dst    : register receiving the adder result
//   is_jmp : unconditional jump
//   is_jnc : jump if carry clear
// Undefined opcodes decode as NOP (zero source, no load, no jump).
module td4_decode
    import td4_pkg::*;
(
    input  logic [3:0] opcode,
    output src_t       src,
    output dst_t       dst,
    output logic       is_jmp,
    output logic       is_jnc
);

    // Opcode to source/destination/jump decode.
    always_comb begin
        src    = SRC_ZERO;
        dst    = DST_NONE;
        is_jmp = 1'b0;
        is_jnc = 1'b0;
        case (opcode)
            OP_ADD_A:  begin src = SRC_A;    dst = DST_A;   end
            OP_MOV_AB: begin src = SRC_B;    dst = DST_A;   end
            OP_IN_A:   begin src = SRC_IN;   dst = DST_A;   end
            OP_MOV_AI: begin src = SRC_ZERO; dst = DST_A;   end
            OP_MOV_BA: begin src = SRC_A;    dst = DST_B;   end
            OP_ADD_B:  begin src = SRC_B;    dst = DST_B;   end
            OP_IN_B:   begin src = SRC_IN;   dst = DST_B;   end
            OP_MOV_BI: begin src = SRC_ZERO; dst = DST_B;   end
            OP_OUT_B:  begin src = SRC_B;    dst = DST_OUT; end
            OP_OUT_I:  begin src = SRC_ZERO; dst = DST_OUT; end
            OP_JNC:    begin is_jnc = 1'b1; end
            OP_JMP:    begin is_jmp = 1'b1; end
            default:   begin src = SRC_ZERO; dst = DST_NONE; end
        endcase
    end

endmodule

// File: rtl/td4_sequencer.sv
// td4_sequencer: two-cycle (FETCH, EXEC) fetch/decode/execute controller
// of the TD4 4-bit CPU. Owns PC and the carry flag and drives the register
// load bus.
//   CLK      : clock, rising edge
//   CLR      : asynchronous active-low reset
//   EN       : run enable; 0 freezes state/PC/C and blocks all loads
//   rom_addr : instruction address (= PC)
//   rom_data : synchronous ROM word, valid one cycle after rom_addr
//   IN       : input port
//   C        : carry flag
//   halted   : sticky, set when the program jumps to itself
//   bus      : register load bus (Im, LOAD_A/B/OUT out; A, B in)
module td4_sequencer
    import td4_pkg::*;
#(
    parameter int             DW     = 4,
    parameter int             IW     = 8,
    parameter logic [DW-1:0]  PC_RST = 4'h0
) (
    input  logic            CLK,
    input  logic            CLR,
    input  logic            EN,
    output logic [DW-1:0]   rom_addr,
    input  logic [IW-1:0]   rom_data,
    input  logic [DW-1:0]   IN,
    output logic            C,
    output logic            halted,
    td4_sequencer_if.master bus
);

    state_t        state_r;
    state_t        state_nxt_s;
    logic [DW-1:0] pc_r;
    logic          c_r;
    logic          halted_r;

    logic          exec_s;
    logic          fire_s;
    logic [IW-1:0] word_s;
    logic [3:0]    opcode_s;
    logic [DW-1:0] imm_s;
    src_t          src_s;
    dst_t          dst_s;
    logic          is_jmp_s;
    logic          is_jnc_s;
    logic [DW-1:0] src_val_s;
    logic [DW:0]   sum_s;
    logic          jump_s;
    logic [DW-1:0] pc_nxt_s;
    logic          halt_set_s;

    assign exec_s = (state_r == ST_EXEC);
    // The ROM word is only meaningful in EXEC; masking it in FETCH keeps
    // an undefined ROM output from reaching Im or the strobes.
    assign word_s   = exec_s ? rom_data : {IW{1'b0}};
    assign opcode_s = word_s[IW-1:IW-4];
    assign imm_s    = word_s[DW-1:0];

    td4_decode u_decode (
        .opcode (opcode_s),
        .src    (src_s),
        .dst    (dst_s),
        .is_jmp (is_jmp_s),
        .is_jnc (is_jnc_s)
    );

    // Adder source multiplexer and 5-bit sum (carry out in the top bit).
    always_comb begin
        src_val_s = {DW{1'b0}};
        case (src_s)
            SRC_A:    src_val_s = bus.A;
            SRC_B:    src_val_s = bus.B;
            SRC_IN:   src_val_s = IN;
            SRC_ZERO: src_val_s = {DW{1'b0}};
            default:  src_val_s = {DW{1'b0}};
        endcase
        sum_s = {1'b0, src_val_s} + {1'b0, imm_s};
    end

    // Next PC and self-jump detection; JNC looks at the flag before this edge.
    always_comb begin
        jump_s     = is_jmp_s | (is_jnc_s & ~c_r);
        halt_set_s = 1'b0;
        if (jump_s) begin
            pc_nxt_s   = imm_s;
            halt_set_s = (imm_s == pc_r);
        end else begin
            pc_nxt_s   = pc_r + DW'(1);
        end
    end

    // FSM next state: FETCH and EXEC simply alternate.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_FETCH: state_nxt_s = ST_EXEC;
            ST_EXEC:  state_nxt_s = ST_FETCH;
            default:  state_nxt_s = ST_FETCH;
        endcase
    end

    // Register bus drive: result and strobes only in EXEC, strobes only while running.
    always_comb begin
        fire_s       = exec_s & EN & CLR;
        bus.LOAD_A   = 1'b0;
        bus.LOAD_B   = 1'b0;
        bus.LOAD_OUT = 1'b0;
        if (exec_s && CLR) begin
            bus.Im = sum_s[DW-1:0];
        end else begin
            bus.Im = {DW{1'b0}};
        end
        if (fire_s) begin
            bus.LOAD_A   = (dst_s == DST_A);
            bus.LOAD_B   = (dst_s == DST_B);
            bus.LOAD_OUT = (dst_s == DST_OUT);
        end else begin
            bus.LOAD_A   = 1'b0;
            bus.LOAD_B   = 1'b0;
            bus.LOAD_OUT = 1'b0;
        end
    end

    // State, PC, carry and halted registers; only an enabled EXEC edge commits.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_r  <= ST_FETCH;
            pc_r     <= PC_RST;
            c_r      <= 1'b0;
            halted_r <= 1'b0;
        end else if (EN) begin
            state_r <= state_nxt_s;
            if (exec_s) begin
                pc_r     <= pc_nxt_s;
                c_r      <= sum_s[DW];
                halted_r <= halted_r | halt_set_s;
            end
        end
    end

    assign rom_addr = pc_r;
    assign C        = c_r;
    assign halted   = halted_r;

endmodule

// File: tb/tb_td4_sequencer.sv
// tb_td4_sequencer: directed bench for td4_sequencer. Holds an ISA-level
// model (PC, carry, A, B, OUT, halted, fetch/execute phase) that is compared
// with the DUT every falling edge, plus literal checkpoints along the program.
module tb_td4_sequencer;

    logic       clk = 1'b0;
    logic       CLR = 1'b1;
    logic       EN  = 1'b1;
    logic [3:0] IN  = 4'h0;
    logic [3:0] rom_addr;
    logic [7:0] rom_data;
    logic       C;
    logic       halted;

    logic [7:0] rom [16];
    logic [3:0] a_reg   = 4'h0;
    logic [3:0] b_reg   = 4'h0;
    logic [3:0] out_reg = 4'h0;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    td4_sequencer_if #(.DW(4)) bus ();

    td4_sequencer #(.DW(4), .IW(8), .PC_RST(4'h0)) dut (
        .CLK      (clk),
        .CLR      (CLR),
        .EN       (EN),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .IN       (IN),
        .C        (C),
        .halted   (halted),
        .bus      (bus.master)
    );

    always #5 clk = ~clk;

    // Environment: synchronous ROM and the three registers the sequencer loads.
    always @(posedge clk) begin
        rom_data <= rom[rom_addr];
        if (bus.LOAD_A)   a_reg   <= bus.Im;
        if (bus.LOAD_B)   b_reg   <= bus.Im;
        if (bus.LOAD_OUT) out_reg <= bus.Im;
    end
    assign bus.A = a_reg;
    assign bus.B = b_reg;

    // ---------------- ISA-level model ----------------
    logic [3:0] mpc = 4'h0;
    logic       mc = 1'b0, mhalt = 1'b0, mexec = 1'b0;
    logic [3:0] ma = 4'h0, mb = 4'h0, mout = 4'h0;

    logic [7:0] m_w;
    logic [3:0] m_op, m_imm, m_srcv, m_npc;
    logic [4:0] m_sum;
    int         m_dst;   // 0 none, 1 A, 2 B, 3 OUT
    logic       m_taken;

    always @* begin
        m_w   = rom[mpc];
        m_op  = m_w[7:4];
        m_imm = m_w[3:0];
        if (m_op == 4'd0 || m_op == 4'd4)                      m_srcv = ma;
        else if (m_op == 4'd1 || m_op == 4'd5 || m_op == 4'd9) m_srcv = mb;
        else if (m_op == 4'd2 || m_op == 4'd6)                 m_srcv = IN;
        else                                                   m_srcv = 4'h0;
        m_sum = 5'(m_srcv) + 5'(m_imm);
        if (m_op < 4'd4)                      m_dst = 1;
        else if (m_op < 4'd8)                 m_dst = 2;
        else if (m_op == 4'd9 || m_op == 4'd11) m_dst = 3;
        else                                  m_dst = 0;
        m_taken = (m_op == 4'd15) || (m_op == 4'd14 && !mc);
        m_npc   = m_taken ? m_imm : mpc + 4'd1;
    end

    // Model state: one instruction retires on every second enabled edge.
    always @(posedge clk or negedge CLR) begin
        if (!CLR) begin
            mpc <= 4'h0; mc <= 1'b0; mhalt <= 1'b0; mexec <= 1'b0;
        end else if (EN) begin
            if (!mexec) begin
                mexec <= 1'b1;
            end else begin
                mexec <= 1'b0;
                mc    <= m_sum[4];
                mpc   <= m_npc;
                if (m_taken && m_imm == mpc) mhalt <= 1'b1;
                if (m_dst == 1) ma   <= m_sum[3:0];
                if (m_dst == 2) mb   <= m_sum[3:0];
                if (m_dst == 3) mout <= m_sum[3:0];
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("rom_addr", int'(rom_addr), int'(mpc));
            chk("C", int'(C), int'(mc));
            chk("halted", int'(halted), int'(mhalt));
            chk("Im", int'(bus.Im), (mexec && CLR) ? int'(m_sum[3:0]) : 0);
            chk("LOAD_A", int'(bus.LOAD_A), int'(mexec && EN && CLR && m_dst == 1));
            chk("LOAD_B", int'(bus.LOAD_B), int'(mexec && EN && CLR && m_dst == 2));
            chk("LOAD_OUT", int'(bus.LOAD_OUT), int'(mexec && EN && CLR && m_dst == 3));
            chk("reg_A", int'(a_reg), int'(ma));
            chk("reg_B", int'(b_reg), int'(mb));
            chk("reg_OUT", int'(out_reg), int'(mout));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 8'h80;
        rom[0]  = 8'h33;  // MOV A,3
        rom[1]  = 8'h3E;  // MOV A,E
        rom[2]  = 8'h03;  // ADD A,3 -> A=1, C=1
        rom[3]  = 8'hE5;  // JNC 5 with C=1 -> PC=4, C=0
        rom[4]  = 8'hE9;  // JNC 9 with C=0 -> PC=9
        rom[9]  = 8'h76;  // MOV B,6
        rom[10] = 8'h90;  // OUT B
        rom[11] = 8'hFF;  // JMP F
        rom[15] = 8'h80;  // NOP, PC wraps to 0

        #1 CLR = 1'b0;
        step(1);
        chk_en = 1'b1;
        CLR = 1'b1;
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_Im", int'(bus.Im), 0);
        chk("rst_halted", int'(halted), 0);

        step(1);
        chk("mova3_Im", int'(bus.Im), 3);
        chk("mova3_LOAD_A", int'(bus.LOAD_A), 1);
        step(1);
        chk("mova3_A", int'(a_reg), 3);
        chk("mova3_pc", int'(rom_addr), 1);
        step(4);
        chk("add_A", int'(a_reg), 1);
        chk("add_C", int'(C), 1);
        step(2);
        chk("jnc_nt_pc", int'(rom_addr), 4);
        chk("jnc_nt_C", int'(C), 0);
        step(2);
        chk("jnc_t_pc", int'(rom_addr), 9);
        chk("jnc_t_halted", int'(halted), 0);
        step(2);
        chk("movb_B", int'(b_reg), 6);

        // OUT B, stalled three cycles in EXEC.
        step(1);
        EN = 1'b0;
        step(3);
        chk("stall_LOAD_OUT", int'(bus.LOAD_OUT), 0);
        chk("stall_pc", int'(rom_addr), 10);
        EN = 1'b1;
        #1;
        chk("resume_LOAD_OUT", int'(bus.LOAD_OUT), 1);
        chk("resume_Im", int'(bus.Im), 6);
        step(1);
        chk("out_reg", int'(out_reg), 6);
        step(4);
        chk("wrap_pc", int'(rom_addr), 0);
        chk("wrap_C", int'(C), 0);

        // Second program, loaded while in reset.
        CLR = 1'b0;
        rom[0] = 8'h51;  // ADD B,1
        rom[1] = 8'h1C;  // MOV A,B imm C -> 7+12=19: A=3, C=1
        rom[2] = 8'hEA;  // JNC A with C=1 -> PC=3, C=0
        rom[3] = 8'h23;  // IN A imm 3, IN=F -> A=2, C=1
        rom[4] = 8'hB5;  // OUT 5, C=0
        rom[5] = 8'hC0;  // undefined -> NOP
        rom[6] = 8'hF6;  // JMP 6 (self)
        IN = 4'hF;
        step(1);
        CLR = 1'b1;
        step(1);
        chk("addb_LOAD_B", int'(bus.LOAD_B), 1);
        CLR = 1'b0;
        #1;
        chk("abort_LOAD_B", int'(bus.LOAD_B), 0);
        chk("abort_pc", int'(rom_addr), 0);
        step(1);
        chk("abort_B", int'(b_reg), 6);
        CLR = 1'b1;
        step(2);
        chk("addb_B", int'(b_reg), 7);
        step(2);
        chk("movab_A", int'(a_reg), 3);
        chk("movab_C", int'(C), 1);
        step(2);
        chk("jnc2_pc", int'(rom_addr), 3);
        step(2);
        chk("in_A", int'(a_reg), 2);
        step(2);
        chk("outi_reg", int'(out_reg), 5);
        step(4);
        chk("self_halted", int'(halted), 1);
        chk("self_pc", int'(rom_addr), 6);
        step(6);
        chk("sticky_halted", int'(halted), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
